// File: rtl/manchester_encoder_tx_if.sv
// Valid/ready word handshake feeding the Manchester line transmitter.
interface manchester_encoder_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/manchester_encoder_tx.sv
// Manchester transmitter: alternating preamble then payload MSB first.
// Each bit cell is two H-cycle half levels; the second half carries the data value.
module manchester_encoder_tx #(
  parameter int BIT_PERIOD_CLKS = 100,
  parameter int DATA_WIDTH      = 8,
  parameter int PREAMBLE_BITS   = 8
) (
  input  logic                    clk_sys,
  input  logic                    rst,
  manchester_encoder_tx_if.slave  tx,
  output logic                    manchester_out,
  output logic                    tx_busy,
  output logic                    tx_done
);
  localparam int H    = BIT_PERIOD_CLKS / 2;
  localparam int TW   = (H > 1) ? $clog2(H) : 1;
  localparam int MAXB = (PREAMBLE_BITS > DATA_WIDTH) ? PREAMBLE_BITS : DATA_WIDTH;
  localparam int CW   = $clog2(MAXB + 1);
  localparam logic [TW-1:0] T_LAST = TW'(H - 1);
  localparam logic [CW-1:0] P_LAST = CW'(PREAMBLE_BITS - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  state_t                state, state_n;
  logic [TW-1:0]         timer, timer_n;
  logic                  half, half_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [DATA_WIDTH-1:0] sh, sh_n;
  logic                  bit_n, line_n;

  assign tx.tx_ready = (state == IDLE) && !rst;
  assign tx_busy     = (state != IDLE);
  assign tx_done     = (state == DATA) && half && (timer == T_LAST) && (cnt == D_LAST);

  always_comb begin
    state_n = state;
    timer_n = timer;
    half_n  = half;
    cnt_n   = cnt;
    sh_n    = sh;
    case (state)
      IDLE: begin
        if (tx.tx_valid && tx.tx_ready) begin
          sh_n    = tx.tx_data;
          timer_n = '0;
          half_n  = 1'b0;
          cnt_n   = '0;
          state_n = (PREAMBLE_BITS > 0) ? PREAMBLE : DATA;
        end
      end
      default: begin
        if (timer == T_LAST) begin
          timer_n = '0;
          half_n  = ~half;
          if (half) begin
            cnt_n = cnt + 1'b1;
            if (state == DATA) sh_n = sh << 1;
            if (state == PREAMBLE && cnt == P_LAST) begin
              cnt_n   = '0;
              state_n = DATA;
            end else if (state == DATA && cnt == D_LAST) begin
              cnt_n   = '0;
              state_n = IDLE;
            end
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
    endcase
    // Line is registered, so it is derived from where the frame will be next cycle.
    bit_n  = (state_n == PREAMBLE) ? ~cnt_n[0] : sh_n[DATA_WIDTH-1];
    line_n = (state_n == IDLE) ? 1'b0 : (half_n ? bit_n : ~bit_n);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state          <= IDLE;
      timer          <= '0;
      half           <= 1'b0;
      cnt            <= '0;
      sh             <= '0;
      manchester_out <= 1'b0;
    end else begin
      state          <= state_n;
      timer          <= timer_n;
      half           <= half_n;
      cnt            <= cnt_n;
      sh             <= sh_n;
      manchester_out <= line_n;
    end
  end
endmodule

// File: tb/tb_manchester_encoder_tx.sv
// Directed bench: per-cycle expected line levels queued at handshake, popped as the frame plays out.
module tb_manchester_encoder_tx;
  localparam int BP  = 8;
  localparam int H   = BP / 2;
  localparam int PRE = 4;
  localparam int DW  = 8;
  localparam int F   = (PRE + DW) * BP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_out, a_busy, a_done;
  logic b_out, b_busy, b_done;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  manchester_encoder_tx_if #(.DATA_WIDTH(DW)) a_if ();
  manchester_encoder_tx_if #(.DATA_WIDTH(1))  b_if ();

  manchester_encoder_tx #(.BIT_PERIOD_CLKS(BP), .DATA_WIDTH(DW), .PREAMBLE_BITS(PRE)) dut_a (
    .clk_sys(clk), .rst(rst), .tx(a_if),
    .manchester_out(a_out), .tx_busy(a_busy), .tx_done(a_done));

  manchester_encoder_tx #(.BIT_PERIOD_CLKS(BP), .DATA_WIDTH(1), .PREAMBLE_BITS(0)) dut_b (
    .clk_sys(clk), .rst(rst), .tx(b_if),
    .manchester_out(b_out), .tx_busy(b_busy), .tx_done(b_done));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_bit(input logic b);
    for (int i = 0; i < H; i++) exp_q.push_back(~b);
    for (int i = 0; i < H; i++) exp_q.push_back(b);
  endtask

  task automatic push_frame(input logic [DW-1:0] d);
    for (int i = 0; i < PRE; i++) push_bit((i % 2) == 0);
    for (int i = DW - 1; i >= 0; i--) push_bit(d[i]);
  endtask

  // Called just after a negedge; returns right after the negedge of the accept cycle.
  task automatic start_frame(input logic [DW-1:0] d, output int waits);
    a_if.tx_data  = d;
    a_if.tx_valid = 1'b1;
    #1;
    waits = 0;
    while (a_if.tx_ready !== 1'b1 && waits < 200) begin
      @(negedge clk); #1;
      waits++;
    end
    chk("accept_ready", a_if.tx_ready, 1'b1);
    push_frame(d);
  endtask

  task automatic run_frame(input logic [DW-1:0] d, input int hold, input logic [DW-1:0] next_d,
                           input int inj, input int rst_at);
    logic [DW-1:0] dec;
    logic          e;
    int            ab;
    dec = '0;
    ab  = 0;
    for (int k = 1; k <= F && ab == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        if (hold != 0) a_if.tx_data = next_d;
        else a_if.tx_valid = 1'b0;
      end
      if (inj != 0 && k == inj) begin a_if.tx_data = 8'hFF; a_if.tx_valid = 1'b1; end
      if (inj != 0 && k == inj + 1) a_if.tx_valid = 1'b0;
      if (rst_at != 0 && k == rst_at) rst = 1'b1;
      if (rst_at != 0 && k == rst_at + 1) rst = 1'b0;
      @(negedge clk);
      if (rst_at != 0 && k == rst_at + 1) begin
        chk("abort_line", a_out, 1'b0);
        chk("abort_busy", a_busy, 1'b0);
        chk("abort_done", a_done, 1'b0);
        exp_q.delete();
        ab = 1;
      end else begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        chk("line", a_out, e);
        chk("done", a_done, (k == F));
        chk("busy", a_busy, 1'b1);
        chk("ready_busy", a_if.tx_ready, 1'b0);
        if ((k - 1) / BP >= PRE && (k - 1) % BP == BP - 1) dec = {dec[DW-2:0], a_out};
      end
    end
    if (ab == 0) begin
      chk("decode", dec, d);
      @(negedge clk);
      chk("idle_line", a_out, 1'b0);
      chk("idle_busy", a_busy, 1'b0);
      chk("idle_done", a_done, 1'b0);
      chk("idle_ready", a_if.tx_ready, 1'b1);
    end
  endtask

  initial begin
    int w;
    a_if.tx_data  = '0;
    a_if.tx_valid = 1'b0;
    b_if.tx_data  = '0;
    b_if.tx_valid = 1'b0;

    // Reset and idle
    repeat (5) begin
      @(negedge clk);
      chk("rst_line", a_out, 1'b0);
      chk("rst_busy", a_busy, 1'b0);
      chk("rst_done", a_done, 1'b0);
      chk("rst_ready", a_if.tx_ready, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", a_if.tx_ready, 1'b1);
    chk("post_rst_line", a_out, 1'b0);

    // Single frame 0xA5
    start_frame(8'hA5, w);
    run_frame(8'hA5, 0, 8'h00, 0, 0);

    // Ignored request during a 0x00 frame
    @(negedge clk);
    start_frame(8'h00, w);
    run_frame(8'h00, 0, 8'h00, 20, 0);

    // Back-to-back 0x3C then 0xC3 with valid held
    @(negedge clk);
    start_frame(8'h3C, w);
    run_frame(8'h3C, 1, 8'hC3, 0, 0);
    start_frame(8'hC3, w);
    chk("b2b_no_wait", w, 0);
    run_frame(8'hC3, 0, 8'h00, 0, 0);

    // Mid-frame reset, then a normal frame
    @(negedge clk);
    start_frame(8'h5A, w);
    run_frame(8'h5A, 0, 8'h00, 0, 40);
    repeat (4) begin
      @(negedge clk);
      chk("post_abort_done", a_done, 1'b0);
      chk("post_abort_line", a_out, 1'b0);
    end
    start_frame(8'h81, w);
    run_frame(8'h81, 0, 8'h00, 0, 0);

    // No preamble, one data bit of value 1
    @(negedge clk);
    b_if.tx_data  = 1'b1;
    b_if.tx_valid = 1'b1;
    #1;
    chk("b_ready", b_if.tx_ready, 1'b1);
    for (int i = 0; i < H; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < H; i++) exp_q.push_back(1'b1);
    for (int k = 1; k <= BP; k++) begin
      logic e;
      @(posedge clk); #1;
      if (k == 1) b_if.tx_valid = 1'b0;
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      chk("b_line", b_out, e);
      chk("b_done", b_done, (k == BP));
      chk("b_busy", b_busy, 1'b1);
    end
    @(negedge clk);
    chk("b_idle_line", b_out, 1'b0);
    chk("b_idle_ready", b_if.tx_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/manchester_encoder_tx.md
# manchester_encoder_tx

Manchester line transmitter for the serial link. It accepts parallel words over a valid/ready handshake and prepends a fixed alternating preamble. It then drives each bit as two equal half-bit line levels, so the data value is the line level in the second half of every bit cell. It sits at the transmit end of the link, and its output pin carries the line read by the link's Manchester receiver.

## Interface
- BIT_PERIOD_CLKS, default 100: length of one bit cell in clk_sys cycles. Must be even and ≥ 4. Half-bit length H = BIT_PERIOD_CLKS/2.
- DATA_WIDTH, default 8: payload bits per frame, 1..32.
- PREAMBLE_BITS, default 8: preamble bits per frame, 0..255.
- clk_sys  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  DATA_WIDTH  payload word, sent MSB first.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block accepts a word this cycle.
- manchester_out  out  1  registered line output; idle level 0.
- tx_busy  out  1  a frame is in progress.
- tx_done  out  1  one-cycle pulse marking the end of a frame.

## Operation
- States: IDLE, PREAMBLE, DATA.
- IDLE
  - tx_ready = 1, and manchester_out holds 0.
  - When tx_valid && tx_ready, capture tx_data into the shift register and clear the half-bit timer and half flag.
  - Go to PREAMBLE, or to DATA if PREAMBLE_BITS = 0.
- Bit encoding:
  - Bit 1 is first half 0, second half 1.
  - Bit 0 is first half 1, second half 0.
  - Every bit cell therefore has a transition at its midpoint.
- PREAMBLE
  - Sends PREAMBLE_BITS bits of the pattern 1,0,1,0,…, starting with 1.
  - After the last preamble bit, go to DATA.
- DATA
  - Sends DATA_WIDTH bits from the shift register, MSB first.
  - The register shifts left by 1 at the end of each bit cell.
  - After the last bit, go to IDLE.
- Counters:
  - Half-bit timer counts 0..H-1.
  - Half flag toggles when the timer wraps.
  - Bit counter counts bits within the current phase and is wide enough for max(PREAMBLE_BITS, DATA_WIDTH).
- tx_ready = (state == IDLE) && !rst. It is combinational.
- tx_valid while tx_ready is low is ignored, and tx_data is not sampled.
- tx_busy = (state != IDLE). It is registered through the state.
- tx_done is asserted in the final clk_sys cycle of the last half-bit of the last DATA bit.
- Reset
  - While rst = 1: state IDLE, manchester_out 0, tx_busy 0, tx_done 0, timer and counters 0, shift register 0.
  - Reset mid-frame aborts the frame immediately. The line is 0 on the cycle after rst is sampled, and no tx_done is issued.

## Timing
- Handshake accepted in cycle N: manchester_out shows the first half-bit of the first frame bit from cycle N+1.
- Each half-bit level holds for exactly H cycles, with no jitter.
- Frame occupies (PREAMBLE_BITS + DATA_WIDTH) × BIT_PERIOD_CLKS cycles: cycles N+1 through N+F, where F is that product.
- tx_done is high in cycle N+F.
- The state is IDLE from N+F+1. manchester_out = 0 and tx_ready = 1 in that cycle.
- Minimum gap between frames: one idle cycle at line level 0.
- Next-frame acceptance is earliest at N+F+1, so the first half-bit of that frame starts at N+F+2.

## Test plan
All scenarios use BIT_PERIOD_CLKS = 8 (H = 4), DATA_WIDTH = 8, PREAMBLE_BITS = 4 unless stated.

- Reset and idle: hold rst 5 cycles, then release.
  - manchester_out = 0, tx_busy = 0, tx_done = 0 throughout.
  - tx_ready = 0 during reset and 1 from the first cycle after release.
- Single frame 0xA5, accepted at cycle N.
  - Half-bit levels from N+1, each held 4 cycles: 0,1 1,0 0,1 1,0 | 0,1 1,0 0,1 1,0 1,0 0,1 1,0 0,1.
  - tx_done is high only at N+96, and tx_ready = 1 at N+97.
- Ignored request: pulse tx_valid with 0xFF at N+20 during a 0x00 frame.
  - Line carries only the 0x00 frame: eight bits of 1,0 after the preamble.
  - Exactly one tx_done occurs.
- Back-to-back: hold tx_valid high with 0x3C then 0xC3.
  - The second handshake occurs exactly at N+97.
  - Line is 0 at N+97, and the second frame begins at N+98.
  - The second frame's payload half-bits decode to 0xC3.
- Mid-frame reset: assert rst at N+40 for 1 cycle.
  - manchester_out = 0 and tx_busy = 0 from N+41.
  - No tx_done occurs, and a new frame is accepted normally afterwards.
- PREAMBLE_BITS = 0, DATA_WIDTH = 1, send 1.
  - Line is 0 for 4 cycles, then 1 for 4 cycles.
  - tx_done is high at N+8.
